pipe_hazard_ctrl: RTL
=====================

// Module: pipe_hazard_ctrl
// PURPOSE
//  Central stall/flush sequencer for the 5-stage pipeline. Drives write-enables and bubble
//  controls for the PC, IF/ID, ID/EX and EX/MEM registers.
//  - Detects load-use hazards and takes taken-branch flushes from EX.
//  - Sequences a multi-cycle multiply in EX: holds upstream stages, injects bubbles into EX/MEM.
//  - Keeps a saturating stall-cycle counter for performance debug.
// PARAMETERS
//  MUL_LAT   4    total cycles a multiply occupies EX; legal range 2..16
//  CNT_W     16   width of stall_cycles statistics counter
// PORTS
//  clk            in   1      rising-edge clock
//  reset          in   1      synchronous, active-high
//  MemRead_EX     in   1      instr in EX is a load
//  WN_EX          in   5      destination reg of instr in EX
//  rs_ID          in   5      source reg rs of instr in ID
//  rt_ID          in   5      source reg rt of instr in ID
//  use_rt_ID      in   1      instr in ID reads rt
//  branch_taken_EX in  1      branch in EX resolved taken
//  mul_start_EX   in   1      instr in EX is a multiply (held high while it sits in EX)
//  PC_Write       out  1      1 = PC may update
//  IFID_Write     out  1      1 = IF/ID may load
//  IFID_Flush     out  1      1 = IF/ID loads a NOP
//  IDEX_Write     out  1      1 = ID/EX may load
//  IDEX_Bubble    out  1      1 = ID/EX loads zero controls
//  EXMEM_Bubble   out  1      1 = EX/MEM loads zero WB/MEM controls
//  mul_busy       out  1      multiply in progress, EX held
//  mul_done       out  1      one-cycle pulse: multiply result valid in EX this cycle
//  stall_cycles   out  CNT_W  count of cycles with PC_Write==0, saturating
// BEHAVIOUR
//  - One clock; reset is synchronous, active-high. State registers update on posedge clk only.
//  - Reset values: state=RUN, cnt=0, stall_cycles=0.
//    While reset is high, outputs are PC_Write=IFID_Write=IDEX_Write=1, all others 0.
//  - FSM states:
//    - RUN: normal issue. mul_start_EX -> stall this cycle, cnt<=MUL_LAT-2, go MUL.
//    - MUL: cnt!=0 -> stall, cnt<=cnt-1. cnt==0 -> no stall, mul_done=1, go RUN
//      (mul_start_EX ignored in this cycle).
//  - Multiply occupies EX for exactly MUL_LAT cycles, of which MUL_LAT-1 are stalled.
//    Example MUL_LAT=4: RUN(stall), MUL cnt2(stall), MUL cnt1(stall), MUL cnt0(done).
//  - Mul stall: PC_Write=IFID_Write=IDEX_Write=0, EXMEM_Bubble=1, mul_busy=1.
//  - Load-use (RUN only, no mul_start_EX, no branch): MemRead_EX && WN_EX!=0 &&
//    (WN_EX==rs_ID || (use_rt_ID && WN_EX==rt_ID))
//    -> PC_Write=IFID_Write=0, IDEX_Bubble=1, single cycle. Combinational from inputs.
//  - Branch flush (RUN, no mul_start_EX): IFID_Flush=1, IDEX_Bubble=1, PC_Write=1;
//    overrides load-use.
//  - Priority: mul (state MUL or mul_start_EX) > branch_taken_EX > load-use > none.
//    branch_taken_EX while in MUL is ignored.
//  - Outputs other than state/cnt/stall_cycles are combinational from state, cnt and inputs.
//  - stall_cycles increments on each non-reset cycle with PC_Write==0; holds at all-ones.
//  - Reset mid-multiply: next cycle state=RUN, cnt=0, no mul_done pulse.
// STRUCTURE
//  - Shared package pipe_ctrl_pkg: state encoding (ST_RUN=1'b0, ST_MUL=1'b1),
//    NOP control constants (WB/MEM zero vectors) reused by ID/EX and EX/MEM.
//  - One sub-module, hazard_detect: pure combinational load-use compare.
//    FSM, counters and priority mux stay in this module.
// TESTING
//  1. Load-use: MemRead_EX=1, WN_EX=8, rs_ID=8
//     -> exactly 1 cycle PC_Write=0, IDEX_Bubble=1; stall_cycles 0->1.
//  2. No hazard on $zero or on unused rt: WN_EX=0 with rs_ID=0, or WN_EX=9=rt_ID with use_rt_ID=0
//     -> no stall.
//  3. Multiply, MUL_LAT=4: mul_start_EX high 4 cycles
//     -> 3 cycles mul_busy=1 and EXMEM_Bubble=1, mul_done on 4th; stall_cycles +=3.
//  4. Branch + load-use in the same cycle -> IFID_Flush=1, IDEX_Bubble=1, PC_Write=1.
//     Branch during MUL -> ignored.
//  5. Reset asserted at MUL cnt1 -> next cycle RUN, all enables 1, no mul_done, stall_cycles=0.
//  6. Saturation, CNT_W=4: 20 back-to-back load-use stalls -> stall_cycles holds at 15.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline-control definitions.
//   - state_t: hazard sequencer state encoding (RUN / MUL).
//   - MUL_CNT_W: width of the multiply countdown. It covers MUL_LAT up to 16,
//     because the counter starts at MUL_LAT-2.
//   - WB_NOP / MEM_NOP: all-zero control vectors. ID/EX and EX/MEM load these
//     when they are bubbled.
package pipe_ctrl_pkg;

  typedef enum logic {
    ST_RUN = 1'b0,
    ST_MUL = 1'b1
  } state_t;

  localparam int MUL_CNT_W = 4;

  localparam logic [1:0] WB_NOP  = 2'b00;
  localparam logic [2:0] MEM_NOP = 3'b000;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard compare (purely combinational).
// Ports:
//   MemRead_EX  in  instr in EX is a load
//   WN_EX       in  destination register of the instr in EX
//   rs_ID       in  rs of the instr in ID
//   rt_ID       in  rt of the instr in ID
//   use_rt_ID   in  instr in ID actually reads rt
//   load_use    out the load result is needed in ID next cycle
module hazard_detect (
  input  logic       MemRead_EX,
  input  logic [4:0] WN_EX,
  input  logic [4:0] rs_ID,
  input  logic [4:0] rt_ID,
  input  logic       use_rt_ID,
  output logic       load_use
);

  // Register $zero never carries a real dependency, so it cannot cause a stall.
  assign load_use = MemRead_EX && (WN_EX != 5'd0) &&
                    ((WN_EX == rs_ID) || (use_rt_ID && (WN_EX == rt_ID)));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline.
// It drives the write-enables and bubble controls of the PC, IF/ID, ID/EX and
// EX/MEM registers. It resolves load-use stalls and taken-branch flushes, and
// it sequences a multi-cycle multiply in EX. It also keeps a saturating count
// of the cycles in which the PC was held.
// Parameters:
//   MUL_LAT  cycles a multiply occupies EX (2..16)
//   CNT_W    width of stall_cycles
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   MemRead_EX, WN_EX               load in EX and its destination register
//   rs_ID, rt_ID, use_rt_ID         source registers of the instr in ID
//   branch_taken_EX, mul_start_EX   EX events
//   PC_Write, IFID_Write, IDEX_Write  register write-enables
//   IFID_Flush, IDEX_Bubble, EXMEM_Bubble  NOP injection controls
//   mul_busy, mul_done              multiply status
//   stall_cycles                    saturating count of PC_Write==0 cycles
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MUL_LAT = 4,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             MemRead_EX,
  input  logic [4:0]       WN_EX,
  input  logic [4:0]       rs_ID,
  input  logic [4:0]       rt_ID,
  input  logic             use_rt_ID,
  input  logic             branch_taken_EX,
  input  logic             mul_start_EX,
  output logic             PC_Write,
  output logic             IFID_Write,
  output logic             IFID_Flush,
  output logic             IDEX_Write,
  output logic             IDEX_Bubble,
  output logic             EXMEM_Bubble,
  output logic             mul_busy,
  output logic             mul_done,
  output logic [CNT_W-1:0] stall_cycles
);

  // The first stalled multiply cycle is spent in RUN, and the last (done)
  // cycle is the MUL cycle with cnt==0. So the countdown starts at MUL_LAT-2.
  localparam logic [MUL_CNT_W-1:0] CNT_INIT = MUL_CNT_W'(MUL_LAT - 2);
  localparam logic [MUL_CNT_W-1:0] CNT_ONE  = MUL_CNT_W'(1);
  localparam logic [CNT_W-1:0]     STAT_ONE = CNT_W'(1);

  state_t               state, state_nxt;
  logic [MUL_CNT_W-1:0] cnt, cnt_nxt;
  logic                 load_use;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + STAT_ONE;
  endfunction

  hazard_detect u_hazard_detect (
    .MemRead_EX (MemRead_EX),
    .WN_EX      (WN_EX),
    .rs_ID      (rs_ID),
    .rt_ID      (rt_ID),
    .use_rt_ID  (use_rt_ID),
    .load_use   (load_use)
  );

  // Next state and priority mux: multiply > taken branch > load-use.
  // While reset is high, every output keeps its default value.
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    PC_Write     = 1'b1;
    IFID_Write   = 1'b1;
    IFID_Flush   = 1'b0;
    IDEX_Write   = 1'b1;
    IDEX_Bubble  = 1'b0;
    EXMEM_Bubble = 1'b0;
    mul_busy     = 1'b0;
    mul_done     = 1'b0;
    if (!reset) begin
      case (state)
        ST_RUN: begin
          if (mul_start_EX) begin
            PC_Write     = 1'b0;
            IFID_Write   = 1'b0;
            IDEX_Write   = 1'b0;
            EXMEM_Bubble = 1'b1;
            mul_busy     = 1'b1;
            cnt_nxt      = CNT_INIT;
            state_nxt    = ST_MUL;
          end else if (branch_taken_EX) begin
            IFID_Flush  = 1'b1;
            IDEX_Bubble = 1'b1;
          end else if (load_use) begin
            PC_Write    = 1'b0;
            IFID_Write  = 1'b0;
            IDEX_Bubble = 1'b1;
          end
        end
        ST_MUL: begin
          // Branch and load-use are not evaluated here. mul_start_EX is still
          // high in the done cycle and must not restart the multiply.
          if (cnt != '0) begin
            PC_Write     = 1'b0;
            IFID_Write   = 1'b0;
            IDEX_Write   = 1'b0;
            EXMEM_Bubble = 1'b1;
            mul_busy     = 1'b1;
            cnt_nxt      = cnt - CNT_ONE;
          end else begin
            mul_done  = 1'b1;
            state_nxt = ST_RUN;
          end
        end
        default: state_nxt = ST_RUN;
      endcase
    end
  end

  // State register and statistics counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_RUN;
      cnt          <= '0;
      stall_cycles <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (!PC_Write) stall_cycles <= sat_inc(stall_cycles);
    end
  end

endmodule
